shift_sipo: RTL and testbench
=============================

SHIFT_SIPO -- requirements
Module: shift_sipo

Interface
REQ-001 Parameter WIDTH, default 4, data bits per frame (2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit lands in parallel_out[WIDTH-1], 0 = lands in parallel_out[0].
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous abort: drops the partial frame and clears overrun.
REQ-006 serial_in  input  1  serial data bit.
REQ-007 serial_valid  input  1  qualifies serial_in; a bit is sampled only at a posedge where serial_valid=1.
REQ-008 parallel_out  output  WIDTH  last accepted frame, registered.
REQ-009 out_valid  output  1  parallel_out holds an undelivered frame.
REQ-010 out_ready  input  1  consumer accepts the frame at a posedge where out_valid=1 and out_ready=1.
REQ-011 busy  output  1  high while a partial frame is held (bit count != 0).
REQ-012 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-013 parity_err  output  1  parity result for the frame on parallel_out; the port is always present.

Function
REQ-014 Bit counter runs 0..FRAME_BITS-1; FRAME_BITS = WIDTH, or WIDTH+1 with parity enabled; it increments only on a sampled bit.
REQ-015 Sampled bit shifts into the shift register in the direction set by MSB_FIRST; the register holds when serial_valid=0, so gaps of any length are allowed mid-frame.
REQ-016 Frame completes at the edge that samples bit FRAME_BITS-1; that same edge wraps the counter to 0.
REQ-017 On completion with out_valid=0, or with out_valid=1 and out_ready=1 at that edge: load parallel_out, set out_valid=1. Latency: out_valid is visible the cycle after the last bit is sampled.
REQ-018 Handshake with no completion at that edge: clear out_valid; parallel_out holds its value.
REQ-019 Completion while out_valid=1 and out_ready=0: drop the new frame, keep parallel_out and out_valid, set overrun=1.
REQ-020 Back-to-back frames with no idle cycle and out_ready held high: deliver every frame, no overrun.
REQ-021 clear=1: counter to 0, shift register to 0, overrun to 0; out_valid and parallel_out are unaffected.
REQ-022 clear=1 together with serial_valid=1: clear wins and the bit is discarded.
REQ-023 overrun clears only via rst or clear.

Reset
REQ-024 rst asserted at any time, including mid-frame, immediately sets: parallel_out=0, out_valid=0, busy=0, overrun=0, parity_err=0, counter=0, shift register=0.
REQ-025 First bit sampled after rst deassertion is bit 0 of a new frame.

Configuration
REQ-026 Macro SHIFT_SIPO_PARITY_EN defined: each frame carries one trailing even-parity bit after the WIDTH data bits. The parity bit is not placed in parallel_out. parity_err = XOR of data and parity bits, loaded with parallel_out. The frame is delivered regardless of parity_err.
REQ-027 Macro undefined: FRAME_BITS = WIDTH and parity_err is tied 0.

Structure
REQ-028 Shared package shift_pkg holds: the default WIDTH constant, the FRAME_BITS derivation, and an even-parity function shared with shift_piso.
REQ-029 One sub-module, sipo_bit_counter (count, wrap, clear, last-bit flag), is instantiated once.

Verification
REQ-030 Reset, then MSB_FIRST=1, bits 1,0,1,1 on 4 consecutive cycles -> parallel_out=4'b1011 and out_valid=1 the next cycle; busy high for 3 cycles.
REQ-031 Same bits with 2 idle cycles between bits 2 and 3 -> parallel_out=4'b1011; MSB_FIRST=0 with the same bits -> 4'b1101.
REQ-032 out_ready=0, frame 1011 then frame 0110 -> parallel_out stays 1011, overrun=1; then clear=1 -> overrun=0.
REQ-033 out_ready=1, frames 1011 and 0100 back-to-back -> two handshakes in order, overrun stays 0.
REQ-034 rst pulse after 2 bits, then bits 0,1,0,0 -> parallel_out=4'b0100, no residue from the aborted frame; repeat using clear=1 with the same result.
REQ-035 SHIFT_SIPO_PARITY_EN defined: bits 1,0,1,1,1 -> parity_err=0; bits 1,0,1,1,0 -> parity_err=1; both frames show parallel_out=1011.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the serial/parallel shifters (shift_sipo, shift_piso).
// SHIFT_SIPO_PARITY_EN adds one trailing even-parity bit to every frame.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_PARITY_BITS = 33;

`ifdef SHIFT_SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Output buffer occupancy for the parallel side.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int frame_bits(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  // XOR of all bits; zero when data plus even-parity bit are consistent.
  function automatic logic even_parity(input logic [MAX_PARITY_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/shift_sipo_if.sv
// Serial input stream and parallel output handshake of shift_sipo.
interface shift_sipo_if
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             clear;
  logic             serial_in;
  logic             serial_valid;
  logic             out_ready;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output clear, serial_in, serial_valid, out_ready,
    input  parallel_out, out_valid, busy, overrun, parity_err
  );

  modport slave (
    input  clear, serial_in, serial_valid, out_ready,
    output parallel_out, out_valid, busy, overrun, parity_err
  );

endinterface

// File: rtl/shift_sipo_bit_counter.sv
// Frame bit counter for shift_sipo: counts sampled bits, wraps after the last one.
module sipo_bit_counter
  import shift_pkg::*;
#(
  parameter int FRAME_BITS = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic step_i,
  output logic last_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST);
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/shift_sipo.sv
// Serial-in parallel-out shifter with a one-frame output buffer and valid/ready handshake.
// SHIFT_SIPO_PARITY_EN: frames carry a trailing even-parity bit checked into parity_err.
module shift_sipo
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  shift_sipo_if.slave bus
);

  // state     | meaning
  // OUT_EMPTY | parallel_out already delivered (or never loaded)
  // OUT_FULL  | parallel_out holds a frame awaiting out_ready

  localparam int FRAME_BITS = frame_bits(WIDTH);

  logic             sample;
  logic             shift_en;
  logic             last_bit;
  logic             cnt_busy;
  logic             complete;
  logic             load_en;
  logic             parity_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic [WIDTH-1:0] frame_data;
  logic [WIDTH-1:0] pout_q;
  logic             perr_q;
  logic             ovr_q, ovr_d;
  out_state_e       state_q, state_d;

  // clear discards any bit offered in the same cycle
  assign sample = bus.serial_valid & ~bus.clear;

  sipo_bit_counter #(
    .FRAME_BITS (FRAME_BITS)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.clear),
    .step_i  (sample),
    .last_o  (last_bit),
    .busy_o  (cnt_busy)
  );

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shift_nxt = {shift_q[WIDTH-2:0], bus.serial_in};
    end else begin : g_lsb
      assign shift_nxt = {bus.serial_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SHIFT_SIPO_PARITY_EN
  // The parity bit is the last frame bit and never enters the data register.
  assign shift_en   = sample & ~last_bit;
  assign frame_data = shift_q;
  assign parity_d   = even_parity(MAX_PARITY_BITS'({shift_q, bus.serial_in}));
`else
  assign shift_en   = sample;
  assign frame_data = shift_nxt;
  assign parity_d   = 1'b0;
`endif

  assign complete = sample & last_bit;

  always_comb begin
    shift_d = shift_q;
    if (bus.clear) begin
      shift_d = '0;
    end else if (shift_en) begin
      shift_d = shift_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    ovr_d   = ovr_q;
    if (bus.clear) begin
      ovr_d = 1'b0;
    end
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          load_en = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          if (bus.out_ready) begin
            load_en = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      shift_q <= '0;
      pout_q  <= '0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      ovr_q   <= ovr_d;
      if (load_en) begin
        pout_q <= frame_data;
        perr_q <= parity_d;
      end
    end
  end

  assign bus.parallel_out = pout_q;
  assign bus.out_valid    = (state_q == OUT_FULL);
  assign bus.busy         = cnt_busy;
  assign bus.overrun      = ovr_q;
  assign bus.parity_err   = perr_q;

endmodule

// File: tb/tb_shift_sipo.sv
// Directed bench for shift_sipo: an MSB-first and an LSB-first instance share one stimulus.
module tb_shift_sipo;
  import shift_pkg::*;

  localparam int W  = 4;
  localparam int FB = frame_bits(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0, sin = 1'b0, sval = 1'b0, ordy = 1'b0;

  always #5 clk = ~clk;

  shift_sipo_if #(.WIDTH(W)) ifm ();
  shift_sipo_if #(.WIDTH(W)) ifl ();

  assign ifm.clear = clear;  assign ifm.serial_in = sin;
  assign ifm.serial_valid = sval;  assign ifm.out_ready = ordy;
  assign ifl.clear = clear;  assign ifl.serial_in = sin;
  assign ifl.serial_valid = sval;  assign ifl.out_ready = ordy;

  shift_sipo #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(ifm.slave));
  shift_sipo #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(ifl.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] hs_q[$];
  bit           mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && ifm.out_valid && ifm.out_ready) hs_q.push_back(ifm.parallel_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sval = 1'b1;
    sin  = b;
    @(posedge clk); #1;
    sval = 1'b0;
    sin  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // bits[W-1] is sent first; gap_len idle cycles are inserted before bit index gap_at.
  task automatic send_frame(input logic [W-1:0] bits, input int gap_at, input int gap_len,
                            input logic flip, input bit chk_busy);
    for (int i = 0; i < W; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          idle(1);
          if (chk_busy) check("gap_busy", 32'(ifm.busy), 32'd1);
        end
      end
      send_bit(bits[W-1-i]);
      if (chk_busy && i < FB - 1) check("busy_mid", 32'(ifm.busy), 32'd1);
    end
`ifdef SHIFT_SIPO_PARITY_EN
    send_bit((^bits) ^ flip);
`else
    if (flip) $display("note: parity flip ignored without parity");
`endif
    if (chk_busy) check("busy_end", 32'(ifm.busy), 32'd0);
  endtask

  task automatic drain();
    ordy = 1'b1;
    idle(1);
    ordy = 1'b0;
    check("drain_valid", 32'(ifm.out_valid), 32'd0);
  endtask

  initial begin
    #3;
    check("rst_pout", 32'(ifm.parallel_out), 32'h0);
    check("rst_valid", 32'(ifm.out_valid), 32'd0);
    check("rst_busy", 32'(ifm.busy), 32'd0);
    check("rst_ovr", 32'(ifm.overrun), 32'd0);
    check("rst_perr", 32'(ifm.parity_err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // basic MSB/LSB frame with busy profile
    send_frame(4'b1011, -1, 0, 1'b0, 1'b1);
    check("f1_valid", 32'(ifm.out_valid), 32'd1);
    check("f1_pout_msb", 32'(ifm.parallel_out), 32'hB);
    check("f1_pout_lsb", 32'(ifl.parallel_out), 32'hD);
    check("f1_perr", 32'(ifm.parity_err), 32'd0);
    drain();
    check("f1_pout_hold", 32'(ifm.parallel_out), 32'hB);

    // idle gap mid-frame
    send_frame(4'b1011, 3, 2, 1'b0, 1'b1);
    check("gap_valid", 32'(ifm.out_valid), 32'd1);
    check("gap_pout_msb", 32'(ifm.parallel_out), 32'hB);
    check("gap_pout_lsb", 32'(ifl.parallel_out), 32'hD);
    drain();

    // overrun: second frame dropped while first undelivered
    send_frame(4'b1011, -1, 0, 1'b0, 1'b0);
    check("ovr_pre", 32'(ifm.overrun), 32'd0);
    send_frame(4'b0110, -1, 0, 1'b0, 1'b0);
    check("ovr_set", 32'(ifm.overrun), 32'd1);
    check("ovr_pout", 32'(ifm.parallel_out), 32'hB);
    check("ovr_valid", 32'(ifm.out_valid), 32'd1);
    idle(3);
    check("ovr_sticky", 32'(ifm.overrun), 32'd1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("clr_ovr", 32'(ifm.overrun), 32'd0);
    check("clr_valid_kept", 32'(ifm.out_valid), 32'd1);
    check("clr_pout_kept", 32'(ifm.parallel_out), 32'hB);
    drain();

    // back-to-back frames with out_ready held high
    hs_q.delete();
    mon_en = 1'b1;
    ordy = 1'b1;
    send_frame(4'b1011, -1, 0, 1'b0, 1'b0);
    check("b2b_f1_pout", 32'(ifm.parallel_out), 32'hB);
    send_frame(4'b0100, -1, 0, 1'b0, 1'b0);
    check("b2b_f2_pout", 32'(ifm.parallel_out), 32'h4);
    check("b2b_f2_valid", 32'(ifm.out_valid), 32'd1);
    idle(2);
    mon_en = 1'b0;
    ordy = 1'b0;
    check("b2b_ovr", 32'(ifm.overrun), 32'd0);
    check("b2b_hs_count", 32'(hs_q.size()), 32'd2);
    if (hs_q.size() >= 2) begin
      check("b2b_hs0", 32'(hs_q[0]), 32'hB);
      check("b2b_hs1", 32'(hs_q[1]), 32'h4);
    end

    // async reset mid-frame
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_rst_busy", 32'(ifm.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(ifm.busy), 32'd0);
    check("mid_rst_pout", 32'(ifm.parallel_out), 32'h0);
    check("mid_rst_valid", 32'(ifm.out_valid), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send_frame(4'b0100, -1, 0, 1'b0, 1'b1);
    check("rst_f_pout_msb", 32'(ifm.parallel_out), 32'h4);
    check("rst_f_pout_lsb", 32'(ifl.parallel_out), 32'h2);
    drain();

    // clear mid-frame, with a bit offered in the clear cycle
    send_bit(1'b1);
    send_bit(1'b1);
    clear = 1'b1;
    sval = 1'b1;
    sin = 1'b1;
    idle(1);
    clear = 1'b0;
    sval = 1'b0;
    sin = 1'b0;
    check("clr_busy", 32'(ifm.busy), 32'd0);
    check("clr_no_valid", 32'(ifm.out_valid), 32'd0);
    send_frame(4'b0100, -1, 0, 1'b0, 1'b1);
    check("clr_f_pout_msb", 32'(ifm.parallel_out), 32'h4);
    check("clr_f_pout_lsb", 32'(ifl.parallel_out), 32'h2);
    check("clr_f_valid", 32'(ifm.out_valid), 32'd1);
    drain();

`ifdef SHIFT_SIPO_PARITY_EN
    send_frame(4'b1011, -1, 0, 1'b0, 1'b1);
    check("par_ok_perr", 32'(ifm.parity_err), 32'd0);
    check("par_ok_pout", 32'(ifm.parallel_out), 32'hB);
    drain();
    send_frame(4'b1011, -1, 0, 1'b1, 1'b1);
    check("par_bad_perr", 32'(ifm.parity_err), 32'd1);
    check("par_bad_pout", 32'(ifm.parallel_out), 32'hB);
    check("par_bad_valid", 32'(ifm.out_valid), 32'd1);
    drain();
`else
    check("nopar_perr", 32'(ifm.parity_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
